// File: rtl/blob_bbox_accumulator_pkg.sv
// Shared types for the blob bounding-box accumulator.
// Label width, background label, FSM states and the per-label record.
package blob_bbox_accumulator_pkg;

  localparam int WORD_SIZE = 8;
  localparam int COORD_W   = 16;
  localparam int AREA_W    = 20;

  localparam logic [WORD_SIZE-1:0] BG_LABEL = '0;

  typedef enum logic {
    ACCUM = 1'b0,
    DUMP  = 1'b1
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
    logic [AREA_W-1:0]  area;
  } bbox_t;

endpackage

// File: rtl/blob_bbox_accumulator_bbox_merge.sv
// Combinational init-or-merge of one pixel into a bounding-box record.
// Area saturates at all-ones.
module bbox_merge #(
  parameter int  COORD_W = 16,
  parameter int  AREA_W  = 20,
  parameter type rec_t   = blob_bbox_accumulator_pkg::bbox_t
) (
  input  logic               cur_valid,
  input  rec_t               cur,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output rec_t               nxt
);

  import blob_bbox_accumulator_pkg::*;

  localparam logic [AREA_W-1:0] AREA_MAX = '1;
  localparam logic [AREA_W-1:0] AREA_ONE = AREA_W'(1);

  always_comb begin
    nxt = cur;
    if (!cur_valid) begin
      nxt.x_min = x;
      nxt.x_max = x;
      nxt.y_min = y;
      nxt.y_max = y;
      nxt.area  = AREA_ONE;
    end else begin
      if (x < cur.x_min) nxt.x_min = x;
      if (x > cur.x_max) nxt.x_max = x;
      if (y < cur.y_min) nxt.y_min = y;
      if (y > cur.y_max) nxt.y_max = y;
      if (cur.area != AREA_MAX) begin
        nxt.area = cur.area + AREA_ONE;
      end
    end
  end

endmodule

// File: rtl/blob_bbox_accumulator.sv
// Per-label bounding box and area accumulator; dumps one record per
// used label at frame end over valid/ready, then re-arms.
module blob_bbox_accumulator #(
  parameter int WORD_SIZE  = 8,
  parameter int MAX_LABELS = 256,
  parameter int COORD_W    = 16,
  parameter int AREA_W     = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 frame_end,
  input  logic [WORD_SIZE-1:0] label,
  input  logic [COORD_W-1:0]   x,
  input  logic [COORD_W-1:0]   y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_label,
  output logic [COORD_W-1:0]   out_x_min,
  output logic [COORD_W-1:0]   out_x_max,
  output logic [COORD_W-1:0]   out_y_min,
  output logic [COORD_W-1:0]   out_y_max,
  output logic [AREA_W-1:0]    out_area,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  import blob_bbox_accumulator_pkg::*;

  localparam int IDX_W = $clog2(MAX_LABELS);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MAX_LABELS - 1);

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
    logic [AREA_W-1:0]  area;
  } rec_t;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic [MAX_LABELS-1:0] valid_q, valid_d;
  rec_t                  rec_q [MAX_LABELS];
  rec_t                  rec_d [MAX_LABELS];

  logic [IDX_W-1:0] wr_idx;
  logic             in_range;
  logic             hit;
  rec_t             merged;
  rec_t             cur_rec;
  logic             cur_valid;
  logic             advance;

  assign wr_idx   = label[IDX_W-1:0];
  assign in_range = 32'(label) < 32'(MAX_LABELS);
  assign hit      = (state_q == ACCUM) && en
                  && (label != BG_LABEL) && in_range;

  bbox_merge #(
    .COORD_W (COORD_W),
    .AREA_W  (AREA_W),
    .rec_t   (rec_t)
  ) u_merge (
    .cur_valid (valid_q[wr_idx]),
    .cur       (rec_q[wr_idx]),
    .x         (x),
    .y         (y),
    .nxt       (merged)
  );

  assign cur_rec   = rec_q[idx_q];
  assign cur_valid = valid_q[idx_q];
  // Empty slots are skipped without waiting for the consumer.
  assign advance   = (state_q == DUMP) && (!cur_valid || out_ready);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    valid_d   = valid_q;
    rec_d     = rec_q;
    unique case (state_q)
      ACCUM: begin
        if (hit) begin
          valid_d[wr_idx] = 1'b1;
          rec_d[wr_idx]   = merged;
        end
        if (frame_end) begin
          state_d = DUMP;
          idx_d   = FIRST_IDX;
        end
      end
      DUMP: begin
        if (en || frame_end) overrun_d = 1'b1;
        if (advance) begin
          valid_d[idx_q] = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = ACCUM;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ACCUM;
      idx_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= '0;
      for (int i = 0; i < MAX_LABELS; i++) begin
        rec_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      rec_q     <= rec_d;
    end
  end

  assign out_valid = (state_q == DUMP) && cur_valid;
  assign out_label = out_valid ? WORD_SIZE'(idx_q) : '0;
  assign out_x_min = out_valid ? cur_rec.x_min : '0;
  assign out_x_max = out_valid ? cur_rec.x_max : '0;
  assign out_y_min = out_valid ? cur_rec.y_min : '0;
  assign out_y_max = out_valid ? cur_rec.y_max : '0;
  assign out_area  = out_valid ? cur_rec.area  : '0;
  assign busy      = (state_q == DUMP);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule
